// File: rtl/tables_sweep.sv
// tables_sweep: walks all eight {w,x,y} vectors into a 3-input combinational
// unit, samples its z response after a settle time, and compares each sample
// against the EXPECT truth table.
// Optional build macro: TABLES_SWEEP_STOP_EN stops the sweep at the first mismatch.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | results held, waiting for start
//   S_DRIVE  | vector idx applied; hold counts down, z sampled at hold==0
//   S_FINISH | one cycle: done pulse, pass valid, then back to idle
module tables_sweep #(
    parameter logic [7:0]  EXPECT = 8'hE8,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       z,
    output logic       w,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail,
    output logic [7:0] captured
);

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_FINISH} state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] hold_q, hold_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] err_q, err_d;
    logic [2:0] first_q, first_d;
    logic [7:0] cap_q, cap_d;
    logic       pass_q, pass_d;

    logic sample_edge;
    logic mismatch;
    logic stop_now;

    // Sample qualification and the end-of-sweep decision
    always_comb begin
        sample_edge = (state_q == S_DRIVE) && (hold_q == 4'd0);
        mismatch    = (z != EXPECT[idx_q]);
`ifdef TABLES_SWEEP_STOP_EN
        stop_now    = sample_edge && (mismatch || (idx_q == 3'd7));
`else
        stop_now    = sample_edge && (idx_q == 3'd7);
`endif
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            hold_q  <= 4'd0;
            vec_q   <= 3'd0;
            err_q   <= 4'd0;
            first_q <= 3'd0;
            cap_q   <= 8'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            first_q <= first_d;
            cap_q   <= cap_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_DRIVE;
            S_DRIVE:  if (stop_now) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: vector stepping, settle countdown, capture and scoring
    always_comb begin
        idx_d   = idx_q;
        hold_d  = hold_q;
        vec_d   = vec_q;
        err_d   = err_q;
        first_d = first_q;
        cap_d   = cap_q;
        pass_d  = pass_q;
        if (state_q == S_IDLE && start) begin
            idx_d  = 3'd0;
            hold_d = SETTLE_L;
            vec_d  = 3'd0;
            err_d  = 4'd0;
            cap_d  = 8'd0;
            pass_d = 1'b0;
        end else if (state_q == S_DRIVE) begin
            if (!sample_edge) begin
                hold_d = hold_q - 4'd1;
            end else begin
                cap_d[idx_q] = z;
                if (mismatch) begin
                    err_d = err_q + 4'd1;
                    // first_fail keeps the lowest failing index of this sweep
                    if (err_q == 4'd0) first_d = idx_q;
                end
                if (stop_now) begin
                    // the vector stays on the pins through FINISH
                    pass_d = (err_d == 4'd0);
                end else begin
                    idx_d  = idx_q + 3'd1;
                    vec_d  = idx_q + 3'd1;
                    hold_d = SETTLE_L;
                end
            end
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        busy       = (state_q == S_DRIVE);
        done       = (state_q == S_FINISH);
        {w, x, y}  = vec_q;
        pass       = pass_q;
        err_count  = err_q;
        first_fail = first_q;
        captured   = cap_q;
    end

endmodule

// File: tb/tb_tables_sweep.sv
// Bench for tables_sweep: two instances (SETTLE=2 and SETTLE=0) each driving
// a behavioural model of the unit under test. Expected sweep results are
// queued at start and checked when done pulses.
module tb_tables_sweep;

    typedef struct {
        int         sel;   // 0: SETTLE=2 instance, 1: SETTLE=0 instance
        int         mode;  // 0 maj, 1 w&x|y, 2 stuck0, 3 stuck1, 4 ~maj
        logic [7:0] cap;
        logic [3:0] err;
        logic [2:0] ff;
        logic       pass;
        int         len;   // vectors applied before FINISH
        logic [2:0] last;  // vector left on the pins
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   sel = 0;
    int   mode = 0;

    logic       start2, start0, z2, z0;
    logic       w2, x2, y2, busy2, done2, pass2;
    logic       w0, x0, y0, busy0, done0, pass0;
    logic [3:0] err2, err0;
    logic [2:0] ff2, ff0;
    logic [7:0] cap2, cap0;

    logic       o_busy, o_done, o_pass;
    logic [2:0] o_wxy, o_ff;
    logic [3:0] o_err;
    logic [7:0] o_cap;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[8];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    tables_sweep #(.EXPECT(8'hE8), .SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .z(z2),
        .w(w2), .x(x2), .y(y2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_fail(ff2), .captured(cap2)
    );

    tables_sweep #(.EXPECT(8'hE8), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .z(z0),
        .w(w0), .x(x0), .y(y0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail(ff0), .captured(cap0)
    );

    function automatic logic zf(input int m, input logic [2:0] v);
        logic maj;
        maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
        case (m)
            0: return maj;
            1: return (v[2] & v[1]) | v[0];
            2: return 1'b0;
            3: return 1'b1;
            default: return ~maj;
        endcase
    endfunction

    always_comb begin
        start2 = start && (sel == 0);
        start0 = start && (sel == 1);
        z2 = zf(mode, {w2, x2, y2});
        z0 = zf(mode, {w0, x0, y0});
        if (sel == 0) begin
            o_busy = busy2; o_done = done2; o_pass = pass2;
            o_wxy = {w2, x2, y2}; o_ff = ff2; o_err = err2; o_cap = cap2;
        end else begin
            o_busy = busy0; o_done = done0; o_pass = pass0;
            o_wxy = {w0, x0, y0}; o_ff = ff0; o_err = err0; o_cap = cap0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"}, 32'(o_busy), 0);
        chk({tag, " done"}, 32'(o_done), 0);
        chk({tag, " pass"}, 32'(o_pass), 0);
        chk({tag, " err"}, 32'(o_err), 0);
        chk({tag, " first_fail"}, 32'(o_ff), 0);
        chk({tag, " captured"}, 32'(o_cap), 0);
        chk({tag, " wxy"}, 32'(o_wxy), 0);
    endtask

    // Run one sweep; optionally re-pulse start when the pins show vector rep.
    task automatic run(input vec_t v, input int rep);
        int   settle, cycles;
        logic pulsed;
        vec_t e;
        settle = (v.sel == 0) ? 2 : 0;
        sel = v.sel;
        mode = v.mode;
        @(negedge clk);
        start = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        chk("busy after start", 32'(o_busy), 1);
        cycles = 0;
        pulsed = 1'b0;
        while (o_busy && cycles < 200) begin
            chk("vector on pins", 32'(o_wxy), 32'(cycles / (settle + 1)));
            start = (!pulsed && rep >= 0 && 32'(o_wxy) == 32'(rep));
            pulsed = pulsed | start;
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy length", 32'(cycles), 32'(v.len * (settle + 1)));
        chk("done pulse", 32'(o_done), 1);
        if (exp_q.size() == 0) begin
            chk("scoreboard empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("captured", 32'(o_cap), 32'(e.cap));
            chk("err_count", 32'(o_err), 32'(e.err));
            chk("pass", 32'(o_pass), 32'(e.pass));
            if (!e.pass) chk("first_fail", 32'(o_ff), 32'(e.ff));
            chk("final wxy", 32'(o_wxy), 32'(e.last));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle busy", 32'(o_busy), 0);
            chk("idle done", 32'(o_done), 0);
        end
        chk("result held", 32'(o_cap), 32'(v.cap));
    endtask

    initial begin
        int cycles;
        int dones;
`ifdef TABLES_SWEEP_STOP_EN
        vecs[0] = '{0, 0, 8'hE8, 4'd0, 3'd0, 1'b1, 8, 3'd7};
        vecs[1] = '{0, 1, 8'h02, 4'd1, 3'd1, 1'b0, 2, 3'd1};
        vecs[2] = '{0, 2, 8'h00, 4'd1, 3'd3, 1'b0, 4, 3'd3};
        vecs[3] = '{1, 3, 8'h01, 4'd1, 3'd0, 1'b0, 1, 3'd0};
        vecs[4] = '{1, 4, 8'h01, 4'd1, 3'd0, 1'b0, 1, 3'd0};
        vecs[5] = '{1, 0, 8'hE8, 4'd0, 3'd0, 1'b1, 8, 3'd7};
        vecs[6] = '{1, 1, 8'h02, 4'd1, 3'd1, 1'b0, 2, 3'd1};
        vecs[7] = '{1, 2, 8'h00, 4'd1, 3'd3, 1'b0, 4, 3'd3};
`else
        vecs[0] = '{0, 0, 8'hE8, 4'd0, 3'd0, 1'b1, 8, 3'd7};
        vecs[1] = '{0, 1, 8'hEA, 4'd1, 3'd1, 1'b0, 8, 3'd7};
        vecs[2] = '{0, 2, 8'h00, 4'd4, 3'd3, 1'b0, 8, 3'd7};
        vecs[3] = '{1, 3, 8'hFF, 4'd4, 3'd0, 1'b0, 8, 3'd7};
        vecs[4] = '{1, 4, 8'h17, 4'd8, 3'd0, 1'b0, 8, 3'd7};
        vecs[5] = '{1, 0, 8'hE8, 4'd0, 3'd0, 1'b1, 8, 3'd7};
        vecs[6] = '{1, 1, 8'hEA, 4'd1, 3'd1, 1'b0, 8, 3'd7};
        vecs[7] = '{1, 2, 8'h00, 4'd4, 3'd3, 1'b0, 8, 3'd7};
`endif
        repeat (3) @(negedge clk);
        sel = 0; chk_reset_vals("reset dut2");
        sel = 1; chk_reset_vals("reset dut0");

        // start coincident with rst: rst wins
        sel = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("start under rst busy", 32'(o_busy), 0);

        for (int i = 0; i < 8; i++) run(vecs[i], -1);

        // start re-pulsed at vector 3 is ignored
        run(vecs[0], 3);

        // rst mid-sweep at vector 5
        sel = 0;
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (o_wxy != 3'd5 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        chk("reached vector 5", 32'(o_wxy), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("mid-sweep rst");
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_done) dones++;
        end
        chk("no done after abort", 32'(dones), 0);
        run(vecs[0], -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
